uart_fifo_core: RTL and testbench
=================================

# uart_fifo_core

Parametrised single-clock UART with per-direction baud prescalers, 16x receive oversampling, configurable word length and stop bits, and RX/TX FIFOs with valid/ready handshakes. It sits between the system bus glue and the serial pins. It replaces the dual-clock single-register UART with a block that can absorb bursts and run back-to-back frames.

## Interface
Parameters:
- DATA_BITS, 8: bits per word, legal range 5..9, sent LSB first.
- DIV_W, 16: width of the baud_div input.
- FIFO_DEPTH, 4: entries per FIFO; power of 2, at least 2.

Ports (clock and reset first):
- clk  in  1  single system clock; every flop is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- baud_div  in  DIV_W  oversample tick every baud_div+1 clk; one bit = 16 ticks.
- two_stop  in  1  TX sends 2 stop bits; RX checks only the first.
- tx_valid  in  1  push request into the TX FIFO.
- tx_data  in  DATA_BITS  word to push.
- tx_ready  out  1  TX FIFO not full.
- tx_out  out  1  serial output; idle level is 1.
- tx_busy  out  1  TX FSM not in IDLE.
- rx_in  in  1  serial input, asynchronous to clk.
- rx_valid  out  1  RX FIFO not empty.
- rx_data  out  DATA_BITS  RX FIFO head entry.
- rx_ready  in  1  pop request; pops when rx_valid=1.
- rx_frame_err  out  1  sticky: a stop bit sampled 0.
- rx_overrun  out  1  sticky: a word was dropped because the RX FIFO was full.
- err_clr  in  1  synchronous clear of all sticky flags.
- parity_en, parity_odd  in  1 each  present only with the parity macro.
- rx_parity_err  out  1  sticky; present only with the parity macro.

## Operation
- Reset values: tx_out=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0, all error flags 0. FIFOs are empty and their storage is 0. Both FSMs are in IDLE. Synchroniser flops are 1.
- A reset assertion mid-frame aborts immediately to these values; no partial word is kept.
- Prescalers: TX and RX each have their own counter.
  - A counter produces a tick and returns to 0 when count >= baud_div. The comparison is >=, so lowering baud_div mid-frame never wraps the counter.
  - The TX counter is held at 0 in IDLE.
  - The RX counter is cleared when a start bit is detected.
- TX FSM, states IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE:
  - IDLE: when the FIFO is non-empty, pop the head into the shift register and go to START.
  - Each bit lasts exactly 16 ticks.
  - STOP lasts 16 or 32 ticks, selected by two_stop.
  - At the end of STOP, a non-empty FIFO sends START next with no idle gap.
- RX FSM, states IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE (or WAIT_HIGH):
  - rx_in passes through a 2-flop synchroniser first.
  - IDLE: a synchronised 0 enters START.
  - Each bit is sampled at its mid-point, on the 8th tick.
  - START sampled as 1: false start, return to IDLE with no flags.
  - DATA bits are shifted in LSB first.
  - STOP sampled as 1: push the word. The FSM returns to IDLE immediately after the mid-stop sample so it can resynchronise.
  - STOP sampled as 0: set rx_frame_err, discard the word, and go to WAIT_HIGH. WAIT_HIGH exits to IDLE only after the synchronised line reads 1 (break handling).
  - Push while the FIFO is full: set rx_overrun and drop the new word. If a pop happens in the same cycle, the push is accepted.
- Sticky flags: err_clr clears them. If a set and err_clr happen in the same cycle, set wins.

## Timing
- TX: tx_valid accepted at edge N. FIFO is non-empty after N. tx_busy=1 and tx_out=0 from edge N+2.
- The frame is (1 + DATA_BITS + parity + stops) x 16 x (baud_div+1) clk.
- tx_busy drops on the same edge tx_out finishes STOP, if the FIFO is empty.
- RX: a falling edge on rx_in reaches the FSM after 2 clk of synchroniser delay.
- RX: rx_valid rises 1 clk after the mid-stop sample edge.
- FIFO pop: rx_data updates on the edge after rx_valid && rx_ready.
- Throughput: one word per frame time in each direction; TX and RX are fully independent.

## Configuration
- UART_PARITY_EN defined:
  - Ports parity_en, parity_odd and rx_parity_err exist.
  - With parity_en=1, TX inserts the PARITY state. The parity bit is the XOR of the data bits, inverted when parity_odd=1.
  - RX checks the parity bit. A mismatch sets rx_parity_err and discards the word; the stop bit is still checked.
- Undefined: those ports and the PARITY states are absent. Frames never carry a parity bit.

## Test plan
All scenarios use DATA_BITS=8, FIFO_DEPTH=4, baud_div=0 (16 clk/bit).
- Push 0xA5, two_stop=0 -> tx_out low for 16 clk, then 1,0,1,0,0,1,0,1 at 16 clk each, then high. tx_busy=0 exactly 160 clk after the fall of tx_out.
- Loopback tx_out->rx_in, push 0x00, 0xFF, 0x3C back-to-back -> the three frames are contiguous (480 clk), rx_data pops 0x00, 0xFF, 0x3C in order, and no flags are set.
- Drive a frame with stop bit 0 and hold the line low for 64 clk -> rx_frame_err=1, rx_valid stays 0, no new frame until the line returns high. err_clr clears the flag.
- rx_ready=0, receive 5 frames 0x01..0x05 -> rx_overrun=1 after the 5th. The FIFO pops 0x01..0x04 and 0x05 is lost.
- Pulse rx_in low for 5 clk -> false start, no push, no flag.
- With UART_PARITY_EN, parity_en=1, parity_odd=0, push 0x07 -> parity bit 1. Loopback with the parity bit forced to 0 -> rx_parity_err=1 and the word is not pushed.

Source files
------------

// File: rtl/uart_fifo_core.sv
// Single-clock UART with per-direction prescalers, 16x RX oversampling and TX/RX FIFOs.
// Define UART_PARITY_EN to add the parity bit, its control ports and rx_parity_err.
module uart_fifo_core_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wp[AW-1:0]] <= wdata;
                wp <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
        end
    end

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rdata = mem[rp[AW-1:0]];
endmodule

module uart_fifo_core #(
    parameter int DATA_BITS  = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 two_stop,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy,
    input  logic                 rx_in,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    input  logic                 err_clr
`ifdef UART_PARITY_EN
    ,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic                 rx_parity_err
`endif
);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA,
`ifdef UART_PARITY_EN
        T_PAR,
`endif
        T_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA,
`ifdef UART_PARITY_EN
        R_PAR,
`endif
        R_STOP, R_WAIT
    } rx_state_t;

    // ---------------- TX ----------------
    tx_state_t            tx_state, tx_next;
    logic [DIV_W-1:0]     tx_cnt;
    logic [3:0]           tx_sub, tx_bit_cnt;
    logic                 tx_stop2, tx_pop, tx_line, tx_full, tx_empty, tx_tick, tx_bit_end;
    logic [DATA_BITS-1:0] tx_shift, tx_head;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    uart_fifo_core_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset_n(reset_n), .push(tx_valid && !tx_full), .pop(tx_pop),
        .wdata(tx_data), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
    );

    assign tx_ready   = !tx_full;
    assign tx_tick    = (tx_cnt >= baud_div);
    assign tx_bit_end = tx_tick && (tx_sub == 4'd15);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tx_state <= T_IDLE;
        else          tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        tx_line = 1'b1;
        case (tx_state)
            T_IDLE: if (!tx_empty) begin
                tx_next = T_START;
                tx_pop  = 1'b1;
            end
            T_START: begin
                tx_line = 1'b0;
                if (tx_bit_end) tx_next = T_DATA;
            end
            T_DATA: begin
                tx_line = tx_shift[0];
                if (tx_bit_end && tx_bit_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
                    tx_next = parity_en ? T_PAR : T_STOP;
`else
                    tx_next = T_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            T_PAR: begin
                tx_line = tx_par;
                if (tx_bit_end) tx_next = T_STOP;
            end
`endif
            T_STOP: if (tx_bit_end && (!two_stop || tx_stop2)) begin
                // Chain straight into the next frame when more data is waiting.
                if (!tx_empty) begin
                    tx_next = T_START;
                    tx_pop  = 1'b1;
                end else begin
                    tx_next = T_IDLE;
                end
            end
            default: tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_cnt     <= '0;
            tx_sub     <= '0;
            tx_bit_cnt <= '0;
            tx_stop2   <= 1'b0;
            tx_shift   <= '0;
`ifdef UART_PARITY_EN
            tx_par     <= 1'b0;
`endif
        end else begin
            if (tx_state == T_IDLE) tx_cnt <= '0;
            else if (tx_tick)       tx_cnt <= '0;
            else                    tx_cnt <= tx_cnt + 1'b1;

            if (tx_pop) begin
                tx_shift   <= tx_head;
                tx_sub     <= '0;
                tx_bit_cnt <= '0;
                tx_stop2   <= 1'b0;
`ifdef UART_PARITY_EN
                tx_par     <= (^tx_head) ^ parity_odd;
`endif
            end else if (tx_state != T_IDLE && tx_tick) begin
                tx_sub <= tx_sub + 4'd1;
                if (tx_sub == 4'd15) begin
                    if (tx_state == T_DATA) begin
                        tx_shift   <= tx_shift >> 1;
                        tx_bit_cnt <= tx_bit_cnt + 4'd1;
                    end
                    if (tx_state == T_STOP) tx_stop2 <= 1'b1;
                end
            end
        end
    end

    // Registered pin drivers keep tx_out glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_out  <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            tx_out  <= tx_line;
            tx_busy <= (tx_state != T_IDLE);
        end
    end

    // ---------------- RX ----------------
    rx_state_t            rx_state, rx_next;
    logic [1:0]           rx_sync;
    logic                 rx_s, rx_tick, rx_mid, rx_end, rx_start_det;
    logic [DIV_W-1:0]     rx_cnt;
    logic [3:0]           rx_sub, rx_bit_cnt;
    logic [DATA_BITS-1:0] rx_shift, rx_word_q;
    logic                 rx_push_set, rx_ferr_set, rx_push_q, rx_pop, rx_full, rx_empty;
`ifdef UART_PARITY_EN
    logic                 rx_perr_set, rx_par_bad;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rx_sync <= 2'b11;
        else          rx_sync <= {rx_sync[0], rx_in};
    end

    assign rx_s         = rx_sync[1];
    assign rx_tick      = (rx_cnt >= baud_div);
    assign rx_mid       = rx_tick && (rx_sub == 4'd7);
    assign rx_end       = rx_tick && (rx_sub == 4'd15);
    assign rx_start_det = (rx_state == R_IDLE) && !rx_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rx_state <= R_IDLE;
        else          rx_state <= rx_next;
    end

    always_comb begin
        rx_next     = rx_state;
        rx_push_set = 1'b0;
        rx_ferr_set = 1'b0;
`ifdef UART_PARITY_EN
        rx_perr_set = 1'b0;
`endif
        case (rx_state)
            R_IDLE:  if (!rx_s) rx_next = R_START;
            R_START: begin
                if (rx_mid && rx_s) rx_next = R_IDLE;
                else if (rx_end)    rx_next = R_DATA;
            end
            R_DATA: if (rx_end && rx_bit_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
                rx_next = parity_en ? R_PAR : R_STOP;
`else
                rx_next = R_STOP;
`endif
            end
`ifdef UART_PARITY_EN
            R_PAR: begin
                if (rx_mid) rx_perr_set = (rx_s != ((^rx_shift) ^ parity_odd));
                if (rx_end) rx_next = R_STOP;
            end
`endif
            R_STOP: if (rx_mid) begin
                // Leave at mid-stop so the next start edge is never missed.
                if (rx_s) begin
                    rx_next = R_IDLE;
`ifdef UART_PARITY_EN
                    rx_push_set = !rx_par_bad;
`else
                    rx_push_set = 1'b1;
`endif
                end else begin
                    rx_next     = R_WAIT;
                    rx_ferr_set = 1'b1;
                end
            end
            R_WAIT:  if (rx_s) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_cnt     <= '0;
            rx_sub     <= '0;
            rx_bit_cnt <= '0;
            rx_shift   <= '0;
            rx_word_q  <= '0;
            rx_push_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad <= 1'b0;
`endif
        end else begin
            if (rx_start_det || rx_tick) rx_cnt <= '0;
            else                         rx_cnt <= rx_cnt + 1'b1;

            if (rx_start_det) begin
                rx_sub     <= '0;
                rx_bit_cnt <= '0;
`ifdef UART_PARITY_EN
                rx_par_bad <= 1'b0;
`endif
            end else if (rx_tick) begin
                rx_sub <= rx_sub + 4'd1;
                if (rx_mid && rx_state == R_DATA) rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                if (rx_end && rx_state == R_DATA) rx_bit_cnt <= rx_bit_cnt + 4'd1;
`ifdef UART_PARITY_EN
                if (rx_perr_set) rx_par_bad <= 1'b1;
`endif
            end

            rx_push_q <= rx_push_set;
            if (rx_push_set) rx_word_q <= rx_shift;
        end
    end

    assign rx_pop   = rx_valid && rx_ready;
    assign rx_valid = !rx_empty;

    uart_fifo_core_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset_n(reset_n), .push(rx_push_q && (!rx_full || rx_pop)), .pop(rx_pop),
        .wdata(rx_word_q), .rdata(rx_data), .full(rx_full), .empty(rx_empty)
    );

    // Sticky flags: a set in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
`ifdef UART_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_frame_err  <= rx_ferr_set || (rx_frame_err && !err_clr);
            rx_overrun    <= (rx_push_q && rx_full && !rx_pop) || (rx_overrun && !err_clr);
`ifdef UART_PARITY_EN
            rx_parity_err <= rx_perr_set || (rx_parity_err && !err_clr);
`endif
        end
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Self-checking bench for uart_fifo_core: TX waveform, loopback, framing, overrun, false start.
module tb_uart_fifo_core;
    localparam int DB = 8;
    localparam int DW = 16;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] baud_div = '0;
    logic          two_stop = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic          tx_ready, tx_out, tx_busy;
    logic          rx_in, rx_valid;
    logic [DB-1:0] rx_data;
    logic          rx_ready = 1'b0;
    logic          rx_frame_err, rx_overrun;
    logic          err_clr = 1'b0;
    logic          loop_en = 1'b0;
    logic          rx_drv = 1'b1;
`ifdef UART_PARITY_EN
    logic          parity_en = 1'b0;
    logic          parity_odd = 1'b0;
    logic          rx_parity_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [DB-1:0] exp_q[$];

    assign rx_in = loop_en ? tx_out : rx_drv;

    always #5 clk = ~clk;

    uart_fifo_core #(.DATA_BITS(DB), .DIV_W(DW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset_n(reset_n), .baud_div(baud_div), .two_stop(two_stop),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx_out(tx_out),
        .tx_busy(tx_busy), .rx_in(rx_in), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
        .err_clr(err_clr)
`ifdef UART_PARITY_EN
        , .parity_en(parity_en), .parity_odd(parity_odd), .rx_parity_err(rx_parity_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [DB-1:0] d);
        @(negedge clk);
        chk("tx_ready", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Drive n bits LSB first at the current bit rate, hold the last level, then release high.
    task automatic drive_bits(input logic [15:0] bits, input int n, input int hold);
        int bt = 16 * (int'(baud_div) + 1);
        for (int i = 0; i < n; i++) begin
            rx_drv = bits[i];
            tick(bt);
        end
        tick(hold);
        rx_drv = 1'b1;
    endtask

    task automatic pop_chk(input string tag, input logic [DB-1:0] exp);
        int w = 0;
        while (!rx_valid && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (!rx_valid) chk({tag, "_timeout"}, rx_valid, 1);
        else begin
            chk(tag, rx_data, exp);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    task automatic wait_tx_idle(input int bound);
        int w = 0;
        while (tx_busy && w < bound) begin
            @(negedge clk);
            w++;
        end
        chk("tx_idle_timeout", tx_busy, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] fr;
        logic [DB-1:0] d;
        int cnt, w, n;
        bit exp_ovr;

        // Reset values
        tick(3);
        chk("rst_tx_out", tx_out, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_frame_err", rx_frame_err, 0);
        chk("rst_overrun", rx_overrun, 0);
        reset_n = 1'b1;
        tick(2);

        // Single frame 0xA5: start 16 clk at edge N+2, LSB first, busy drops 160 clk after fall
        fr = {1'b1, 8'hA5, 1'b0};
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("tx_lat_n0", tx_out, 1);
        @(negedge clk);
        chk("tx_lat_n1", tx_out, 1);
        @(negedge clk);
        chk("tx_fall_n2", tx_out, 0);
        chk("tx_busy_n2", tx_busy, 1);
        for (int c = 1; c <= 160; c++) begin
            @(negedge clk);
            if (c % 16 == 8) chk($sformatf("tx_bit%0d", c / 16), tx_out, fr[c/16]);
            if (c == 159) chk("tx_busy_last", tx_busy, 1);
            if (c == 160) begin
                chk("tx_busy_drop", tx_busy, 0);
                chk("tx_idle_line", tx_out, 1);
            end
        end

        // Reset mid-frame aborts and keeps nothing
        push_tx(8'($urandom));
        push_tx(8'($urandom));
        tick(40);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_tx_out", tx_out, 1);
        chk("midrst_busy", tx_busy, 0);
        reset_n = 1'b1;
        tick(30);
        chk("midrst_no_resume", tx_busy, 0);
        chk("midrst_line", tx_out, 1);

        // Loopback, back-to-back frames
        loop_en = 1'b1;
        exp_q = '{8'h00, 8'hFF, 8'h3C};
        cnt = 0;
        w = 0;
        fork
            begin
                push_tx(8'h00);
                push_tx(8'hFF);
                push_tx(8'h3C);
            end
            begin
                while (!tx_busy && w < 50) begin @(negedge clk); w++; end
                while (tx_busy && cnt < 3000) begin @(negedge clk); cnt++; end
                chk("b2b_busy_clk", cnt, 480);
            end
        join
        tick(40);
        while (exp_q.size() > 0) pop_chk("loop_data", exp_q.pop_front());
        chk("loop_empty", rx_valid, 0);
        chk("loop_ferr", rx_frame_err, 0);
        chk("loop_ovr", rx_overrun, 0);

        // Randomised loopback rounds with varying rate and stop bits
        for (int r = 0; r < 4; r++) begin
            baud_div = DW'($urandom_range(0, 2));
            two_stop = 1'($urandom_range(0, 1));
            n = $urandom_range(1, FD);
            for (int k = 0; k < n; k++) begin
                d = 8'($urandom);
                exp_q.push_back(d);
                push_tx(d);
            end
            tick(4);
            wait_tx_idle(n * 12 * 16 * (int'(baud_div) + 1) + 200);
            tick(20 * (int'(baud_div) + 1) + 20);
            while (exp_q.size() > 0) pop_chk($sformatf("rnd%0d_data", r), exp_q.pop_front());
            chk("rnd_empty", rx_valid, 0);
            chk("rnd_ferr", rx_frame_err, 0);
        end
        baud_div = '0;
        two_stop = 1'b0;
        loop_en  = 1'b0;
        tick(20);

        // Stop bit 0 then line held low 64 clk: frame error, no word, wait for high
        drive_bits({6'b0, 1'b0, 8'h55, 1'b0}, 10, 48);
        tick(2);
        chk("ferr_set", rx_frame_err, 1);
        chk("ferr_no_push", rx_valid, 0);
        tick(200);
        chk("ferr_sticky", rx_frame_err, 1);
        chk("ferr_no_ghost", rx_valid, 0);
        drive_bits({6'b0, 1'b1, 8'h96, 1'b0}, 10, 0);
        pop_chk("ferr_recover", 8'h96);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("ferr_clr", rx_frame_err, 0);

        // Overrun: 5 frames with no pops, FIFO keeps the first FD
        exp_ovr = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            drive_bits({6'b0, 1'b1, 8'(v), 1'b0}, 10, 0);
            if (exp_q.size() < FD) exp_q.push_back(8'(v));
            else exp_ovr = 1'b1;
            tick(2);
            chk($sformatf("ovr_after_%0d", v), rx_overrun, exp_ovr);
        end
        while (exp_q.size() > 0) pop_chk("ovr_data", exp_q.pop_front());
        chk("ovr_lost", rx_valid, 0);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("ovr_clr", rx_overrun, 0);

        // Short low pulse: false start
        rx_drv = 1'b0;
        tick(5);
        rx_drv = 1'b1;
        tick(300);
        chk("fstart_no_push", rx_valid, 0);
        chk("fstart_no_ferr", rx_frame_err, 0);

`ifdef UART_PARITY_EN
        // Even parity on 0x07 (three ones) gives a parity bit of 1
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        push_tx(8'h07);
        w = 0;
        while (tx_out && w < 50) begin @(negedge clk); w++; end
        chk("par_fall", tx_out, 0);
        for (int c = 1; c <= 176; c++) begin
            @(negedge clk);
            if (c == 152) chk("par_tx_bit", tx_out, 1'($countones(8'h07) % 2));
            if (c == 168) chk("par_tx_stop", tx_out, 1);
        end
        wait_tx_idle(100);
        drive_bits({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 0);
        tick(4);
        chk("par_err_set", rx_parity_err, 1);
        chk("par_no_push", rx_valid, 0);
        drive_bits({5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 0);
        pop_chk("par_good", 8'h07);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("par_clr", rx_parity_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
